led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Pin-side stage downstream of the on-board blink/status logic. It consumes a 1-bit LED request level and drives the physical LED pin.
- A hard toggle on the request becomes a linear PWM brightness ramp (fade in / fade out) instead of a step.
- It contains its own PWM counter, fade-rate counter and a ramp FSM.
- The clock is the 48 MHz internal-oscillator clock.

Parameters:
- PWM_BITS, 8: duty/PWM counter width; PWM period = PWM_PRESCALE * 2^PWM_BITS clk cycles.
- PWM_PRESCALE, 4: clk cycles per PWM counter increment; legal range >= 1.
- FADE_PERIODS, 2: PWM periods per duty step of +/-1; legal range >= 1.
- SYNC_STAGES, 2: flops in the level_in synchronizer; legal range >= 2.

Ports:
- clk  input  1  system clock (48 MHz HFOSC)
- reset  input  1  asynchronous, active-high reset
- level_in  input  1  LED request level from upstream blink logic; may be asynchronous to clk
- enable  input  1  0 forces LED dark and duty to 0
- duty_max  input  PWM_BITS  brightness target when request is high; sampled every cycle
- led  output  1  PWM drive to LED pin, registered
- duty  output  PWM_BITS  current duty value
- busy  output  1  high while a ramp is in progress (state RAMP_UP or RAMP_DOWN)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs 0 (led=0, duty=0, busy=0); synchronizer, counters and FSM at 0/OFF.
- Synchronizer: level_in passes through SYNC_STAGES flops; level_s is the last stage. No other logic uses level_in.
- Prescaler: pre_cnt counts 0..PWM_PRESCALE-1 and wraps. pwm_cnt increments when pre_cnt wraps.
- period_tick: pulses 1 cycle when pwm_cnt=2^PWM_BITS-1 and pre_cnt wraps.
- Fade counter: fade_cnt counts period_ticks 0..FADE_PERIODS-1. step_tick = period_tick and fade_cnt=FADE_PERIODS-1.
- Target: target = level_s ? duty_max : 0, recomputed each cycle.
- FSM states OFF, RAMP_UP, ON, RAMP_DOWN. Transitions are evaluated every cycle:
  - duty < target -> RAMP_UP.
  - duty > target -> RAMP_DOWN.
  - duty == target -> ON if target != 0, else OFF.
- Duty update: only on step_tick. RAMP_UP: duty += 1. RAMP_DOWN: duty -= 1. No overflow or underflow is possible, because steps are always toward the target.
- Mid-ramp reversal: if level_s changes mid-ramp, the direction reverses on the next cycle from the current duty, with no reset of duty.
- duty_max changes: changes while ON or ramping re-target the same way as a level change.
- LED output: led <= (pwm_cnt < duty), registered, so there is 1 cycle of latency from counter to pin.
  - duty=0 gives led constantly 0.
  - Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS; led is never 100% on. This is by design.
- busy = (state == RAMP_UP or state == RAMP_DOWN), combinational from the state register.
- enable=0 (synchronous): next cycle duty=0, state=OFF, led=0, pre_cnt/pwm_cnt/fade_cnt=0. The synchronizer keeps running.
- enable 0->1: counters start from 0, so the first period_tick occurs PWM_PRESCALE*2^PWM_BITS cycles later.
- Reset asserted mid-ramp: immediate return to reset values; no ramp resumes until reset deasserts and a new target appears.
- Latency: a level_in edge reaches level_s after SYNC_STAGES to SYNC_STAGES+1 cycles. The first duty step then occurs at the next step_tick. A full ramp 0->D takes D*FADE_PERIODS PWM periods.

Decomposition:
- Shared package led_pkg holds:
  - state enum (OFF=2'd0, RAMP_UP=2'd1, ON=2'd2, RAMP_DOWN=2'd3);
  - default PWM_BITS/PWM_PRESCALE/FADE_PERIODS constants;
  - HFOSC_HZ = 48000000.
- One sub-module: led_pwm_timebase, containing pre_cnt, pwm_cnt and fade_cnt. It outputs pwm_cnt, period_tick and step_tick, and takes a clear input driven by !enable.
- FSM, duty register and output compare stay in the top level.

Test Plan:
Bench parameters: PWM_BITS=4, PWM_PRESCALE=1, FADE_PERIODS=1, SYNC_STAGES=2, so PWM period = 16 clk.
- Reset check: assert reset with level_in=1 and duty_max=15 -> led=0, duty=0, busy=0 while reset is high, including asynchronously mid-cycle.
- Fade in: enable=1, duty_max=10, level_in 0->1.
  - Required: busy rises within 3 cycles; duty increments by 1 every 16 cycles.
  - Required: duty=10 after 10 step_ticks, then state ON and busy=0.
  - Required: led is high for exactly 10 of each 16 cycles thereafter.
- Fade out and reversal: from ON at duty=10, set level_in=0. After duty reaches 6, set level_in=1.
  - Required: duty sequence 10,9,8,7,6 then 7,8,9,10, with no jump; state ends ON.
- Target change: ON at duty=10, change duty_max to 4 -> RAMP_DOWN, duty steps to 4, then ON. Change duty_max to 0 -> ramps to 0, state OFF, led stuck 0.
- Enable override: mid RAMP_UP at duty=5, drop enable for 1 cycle.
  - Required: next cycle duty=0, led=0, state OFF.
  - Required: after enable returns with level_s=1, the first step occurs exactly 16 cycles later.
- Extremes: duty_max=15 with level high -> final duty=15 and led high 15 of every 16 cycles. Check level_in glitches shorter than 1 clk produce at most 1-cycle level_s pulses and no illegal FSM state.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared state encoding and default timing constants for the LED fade driver.
package led_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, RAMP_UP = 2'd1, ON = 2'd2, RAMP_DOWN = 2'd3} state_t;
  localparam int PWM_BITS_DEF = 8;
  localparam int PWM_PRESCALE_DEF = 4;
  localparam int FADE_PERIODS_DEF = 2;
  localparam int HFOSC_HZ = 48000000;
endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: prescaler, PWM counter and fade-rate counter producing period and duty-step ticks.
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PWM_PRESCALE = PWM_PRESCALE_DEF,
  parameter int FADE_PERIODS = FADE_PERIODS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_tick,
  output logic                step_tick
);
  localparam int PRE_W = PWM_PRESCALE > 1 ? $clog2(PWM_PRESCALE) : 1;
  localparam int FADE_W = FADE_PERIODS > 1 ? $clog2(FADE_PERIODS) : 1;
  logic [PRE_W-1:0] pre_cnt;
  logic [FADE_W-1:0] fade_cnt;
  logic pre_wrap;
  assign pre_wrap = pre_cnt == PRE_W'(PWM_PRESCALE - 1);
  assign period_tick = !clear && pre_wrap && &pwm_cnt;
  assign step_tick = period_tick && fade_cnt == FADE_W'(FADE_PERIODS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      fade_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      fade_cnt <= '0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
      if (pre_wrap) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (period_tick) fade_cnt <= step_tick ? '0 : fade_cnt + FADE_W'(1);
    end
endmodule

// File: rtl/led_fade_driver.sv
// led_fade_driver: turns a request level into a linear PWM brightness ramp on the LED pin.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PWM_PRESCALE = PWM_PRESCALE_DEF,
  parameter int FADE_PERIODS = FADE_PERIODS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                level_in,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);
  logic [SYNC_STAGES-1:0] sync;
  logic level_s, period_tick, step_tick;
  logic [PWM_BITS-1:0] pwm_cnt, target;
  state_t state, state_nxt;
  led_pwm_timebase #(
    .PWM_BITS(PWM_BITS),
    .PWM_PRESCALE(PWM_PRESCALE),
    .FADE_PERIODS(FADE_PERIODS)
  ) u_timebase (
    .clk(clk),
    .reset(reset),
    .clear(!enable),
    .pwm_cnt(pwm_cnt),
    .period_tick(period_tick),
    .step_tick(step_tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], level_in};
  assign level_s = sync[SYNC_STAGES-1];
  assign target = level_s ? duty_max : '0;
  assign busy = state == RAMP_UP || state == RAMP_DOWN;
  always_comb
    state_nxt = !enable ? OFF :
                duty < target ? RAMP_UP :
                duty > target ? RAMP_DOWN :
                target != '0 ? ON : OFF;
  // Steps follow the live comparison so a step never moves away from the current target.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= OFF;
      duty <= '0;
      led <= 1'b0;
    end else begin
      state <= state_nxt;
      led <= enable && pwm_cnt < duty;
      duty <= !enable ? '0 :
              !step_tick ? duty :
              state_nxt == RAMP_UP ? duty + PWM_BITS'(1) :
              state_nxt == RAMP_DOWN ? duty - PWM_BITS'(1) : duty;
    end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: directed and randomized checks of the fade driver against a cycle-count reference model.
module tb_led_fade_driver;
  localparam int PB = 4;
  localparam int PRE = 1;
  localparam int FADE = 1;
  localparam int SYNC = 2;
  localparam int PER = (1 << PB) * PRE;
  localparam int STEP = PER * FADE;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic level_in = 1'b1;
  logic enable = 1'b0;
  logic [PB-1:0] duty_max = 4'd15;
  logic led, busy;
  logic [PB-1:0] duty;
  int n_chk = 0;
  int n_err = 0;
  int m_duty, m_cnt, m_led, m_busy;
  bit m_q[$];
  led_fade_driver #(
    .PWM_BITS(PB),
    .PWM_PRESCALE(PRE),
    .FADE_PERIODS(FADE),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .level_in(level_in),
    .enable(enable),
    .duty_max(duty_max),
    .led(led),
    .duty(duty),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    m_duty = 0;
    m_cnt = 0;
    m_led = 0;
    m_busy = 0;
    m_q = {};
    repeat (SYNC) m_q.push_back(1'b0);
  endtask
  // Model: level_s is level_in delayed SYNC edges; duty steps once per STEP enabled cycles toward the target.
  task automatic tick();
    int tgt, nd, nc, nl, nb;
    if (reset) begin
      @(posedge clk);
      #1;
      mreset();
    end else begin
      tgt = m_q[$] ? int'(duty_max) : 0;
      if (!enable) begin
        nd = 0; nc = 0; nl = 0; nb = 0;
      end else begin
        nb = int'(m_duty != tgt);
        nd = m_cnt == STEP - 1 ? m_duty + int'(m_duty < tgt) - int'(m_duty > tgt) : m_duty;
        nl = int'(((m_cnt / PRE) % (1 << PB)) < m_duty);
        nc = (m_cnt + 1) % STEP;
      end
      m_q.push_front(level_in);
      void'(m_q.pop_back());
      @(posedge clk);
      #1;
      m_duty = nd; m_cnt = nc; m_led = nl; m_busy = nb;
    end
    chk("duty", duty, m_duty);
    chk("led", led, m_led);
    chk("busy", busy, m_busy);
  endtask
  task automatic wait_duty(input int v, input string tag);
    int k = 0;
    while (duty !== v[PB-1:0] && k < 1000) begin tick(); k++; end
    chk(tag, duty, v);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 1000) begin tick(); k++; end
    chk(tag, busy, 0);
  endtask
  task automatic count_led(input int exp, input string tag);
    int n = 0;
    repeat (PER) begin tick(); n += int'(led); end
    chk(tag, n, exp);
  endtask
  initial begin
    int k;
    mreset();
    #1 reset = 1'b1;
    #1;
    chk("rst_async_duty", duty, 0);
    chk("rst_async_led", led, 0);
    chk("rst_async_busy", busy, 0);
    repeat (3) tick();
    reset = 1'b0;
    enable = 1'b1;
    duty_max = 4'd10;
    level_in = 1'b0;
    repeat (5) tick();
    level_in = 1'b1;
    k = 0;
    do begin tick(); k++; end while (busy !== 1'b1 && k < 3);
    chk("busy_rise", busy, 1);
    wait_duty(10, "fade_in_top");
    wait_idle("fade_in_idle");
    count_led(10, "led_10_of_16");
    level_in = 1'b0;
    wait_duty(6, "fade_out_6");
    level_in = 1'b1;
    wait_idle("reverse_idle");
    chk("reverse_top", duty, 10);
    duty_max = 4'd4;
    wait_duty(4, "retarget_4");
    wait_idle("retarget_idle");
    duty_max = 4'd0;
    wait_duty(0, "retarget_0");
    wait_idle("off_idle");
    count_led(0, "led_dark");
    duty_max = 4'd10;
    wait_duty(5, "ramp_mid_5");
    enable = 1'b0;
    tick();
    chk("dis_duty", duty, 0);
    chk("dis_led", led, 0);
    chk("dis_busy", busy, 0);
    enable = 1'b1;
    k = 0;
    while (duty == '0 && k < 100) begin tick(); k++; end
    chk("first_step_delay", k, PER * FADE);
    duty_max = 4'd15;
    wait_duty(15, "max_duty");
    wait_idle("max_idle");
    count_led(15, "led_15_of_16");
    repeat (20) begin
      level_in = 1'b0;
      #3 level_in = 1'b1;
      tick();
    end
    chk("glitch_duty", duty, 15);
    level_in = 1'b0;
    tick();
    level_in = 1'b1;
    repeat (6) tick();
    repeat (800) begin
      if ($urandom_range(19) == 0) level_in = ~level_in;
      if ($urandom_range(59) == 0) duty_max = PB'($urandom);
      enable = $urandom_range(149) != 0;
      tick();
    end
    enable = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_duty", duty, 0);
    chk("rst_mid_led", led, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
